// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage
//   Elastic pipeline buffer register between two pipeline stages. It carries a
//   packed payload of DATA_W bits with a valid/ready handshake on each side.
//   flush turns every held entry into a bubble. With SKID=1 a second (skid)
//   entry is added so that in_ready comes straight from a flop. With SKID=0
//   there is a single entry and in_ready is combinational.
//
//   Parameters
//     DATA_W    payload width in bits (>=1)
//     BUBBLE    value driven on out_data when no valid entry is held
//     SKID      1: 2-entry buffer, registered in_ready; 0: 1-entry, comb in_ready
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     flush      synchronous kill of all held entries
//     in_valid   upstream entry present
//     in_ready   buffer can accept this cycle
//     in_data    upstream payload
//     out_valid  entry present for downstream
//     out_ready  downstream consumes this cycle
//     out_data   head payload, BUBBLE when out_valid=0
//     occupancy  number of held entries (0..2)
module pipe_buf_stage #(
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int unsigned        SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;   // main entry, drives out_*
  logic [DATA_W-1:0] s_q, s_d;   // skid entry, only reachable with SKID=1
  logic              m_valid;
  logic              accept;
  logic              drain;

  assign m_valid   = (state_q != EMPTY);
  assign out_valid = m_valid;
  assign out_data  = m_q;
  assign occupancy = 2'(state_q);

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          m_d     = in_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          m_d = in_data;
        end else if (accept && (SKID != 0)) begin
          state_d = FULL;
          s_d     = in_data;
        end else if (drain) begin
          state_d = EMPTY;
          m_d     = BUBBLE;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = ONE;
          m_d     = s_q;
          s_d     = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        m_d     = BUBBLE;
        s_d     = BUBBLE;
      end
    endcase
    // A same-cycle accept is dropped; a same-cycle drain has already been
    // taken by downstream, so emptying everything is correct in both cases.
    if (flush) begin
      state_d = EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  if (SKID != 0) begin : g_skid
    // Computed from the next state, so no path from out_ready reaches in_ready.
    logic ready_q;
    always_ff @(posedge clk) begin
      if (reset) ready_q <= 1'b1;
      else       ready_q <= (state_d != FULL);
    end
    assign in_ready = ready_q;
  end else begin : g_noskid
    assign in_ready = ~m_valid | out_ready;
  end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// tb_pipe_buf_stage
//   Drives one SKID=1 and one SKID=0 instance from shared stimulus. Each instance
//   has its own reference queue. An entry is pushed when the handshake accepts
//   it, and popped when downstream drains it. All outputs are compared against
//   the queue on every falling edge.
module tb_pipe_buf_stage;

  localparam int unsigned W   = 8;
  localparam logic [W-1:0] BUB = 8'hEE;

  logic         clk;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [1:0]   a_occ;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occ;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  pipe_buf_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_buf_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: check current outputs, then apply the coming edge.
  always @(negedge clk) begin : monitor
    logic acc, drn, rdy;
    // SKID=1 instance
    rdy = (qa.size() < 2);
    check("a_out_valid", a_out_valid, qa.size() != 0);
    check("a_out_data", a_out_data, (qa.size() != 0) ? qa[0] : BUB);
    check("a_occupancy", a_occ, qa.size());
    check("a_in_ready", a_in_ready, rdy);
    acc = in_valid && rdy;
    drn = (qa.size() != 0) && out_ready;
    if (reset || flush) qa.delete();
    else begin
      if (drn) void'(qa.pop_front());
      if (acc) qa.push_back(in_data);
    end
    // SKID=0 instance
    rdy = (qb.size() == 0) || out_ready;
    check("b_out_valid", b_out_valid, qb.size() != 0);
    check("b_out_data", b_out_data, (qb.size() != 0) ? qb[0] : BUB);
    check("b_occupancy", b_occ, qb.size());
    check("b_in_ready", b_in_ready, rdy);
    acc = in_valid && rdy;
    drn = (qb.size() != 0) && out_ready;
    if (reset || flush) qb.delete();
    else begin
      if (drn) void'(qb.pop_front());
      if (acc) qb.push_back(in_data);
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    // 1: reset held two cycles with in_valid high
    step(1'b1, 8'h55, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    check("t1_out_valid", a_out_valid, 1'b0);
    check("t1_out_data", a_out_data, BUB);
    check("t1_in_ready", a_in_ready, 1'b1);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);

    // 2: streaming at full rate
    step(1'b1, 8'h11, 1'b1);
    check("t2_first_out", a_out_data, 8'h11);
    step(1'b1, 8'h22, 1'b1);
    check("t2_second_out", b_out_data, 8'h22);
    step(1'b1, 8'h33, 1'b1);
    check("t2_occ", a_occ, 2'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // 3: stall fills the skid entry, then release
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h0B, 1'b0);
    check("t3_occ_full", a_occ, 2'd2);
    check("t3_in_ready", a_in_ready, 1'b0);
    step(1'b1, 8'h0C, 1'b0);
    step(1'b1, 8'h0C, 1'b0);
    check("t3_head_held", a_out_data, 8'h0A);
    step(1'b1, 8'h0C, 1'b1);
    step(1'b1, 8'h0C, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // 4: flush while FULL with an offered entry
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h0B, 1'b0);
    flush = 1'b1;
    step(1'b1, 8'h0C, 1'b0);
    flush = 1'b0;
    check("t4_occ", a_occ, 2'd0);
    check("t4_bubble", a_out_data, BUB);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // 5: continuous input, out_ready 1,0,1
    step(1'b1, 8'h40, 1'b1);
    step(1'b1, 8'h41, 1'b0);
    check("t5_b_ready_stall", b_in_ready, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    check("t5_b_stable", b_out_data, 8'h40);
    step(1'b1, 8'h43, 1'b1);
    step(1'b1, 8'h44, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // 6: reset while FULL with in_valid high
    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    reset = 1'b1;
    step(1'b1, 8'h63, 1'b0);
    reset = 1'b0;
    check("t6_a_valid", a_out_valid, 1'b0);
    check("t6_b_valid", b_out_valid, 1'b0);

    // random valid/ready traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      flush = ($urandom_range(0, 63) == 0);
      step(1'(($urandom_range(0, 3)) != 0), 8'($urandom),
           1'($urandom_range(0, 1)));
    end
    flush = 1'b0;
    repeat (4) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
